coeff_sweep_scheduler: RTL

Sequences the coefficient memory for the 128-tap FIR datapath. Per accepted input sample it issues one read sweep over all TAPS coefficient addresses and emits tap-aligned qualifiers for the MAC. It also owns the memory write port: host coefficient writes are buffered and committed only between sweeps, so coefficients never change mid-sample.

---
 rtl/coeff_sweep_scheduler_if.sv | 48 ++++
 rtl/coeff_sweep_scheduler.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/coeff_sweep_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : coeff_sweep_scheduler_if
//  Purpose  : Bundles the sample handshake, the host coefficient write port,
//             the coefficient memory port and the tap qualifiers of the
//             coefficient sweep scheduler.
//             master = scheduler side, slave = surrounding datapath/host.
//  Revision : 1.0  initial release
// ============================================================================
interface coeff_sweep_scheduler_if #(
    parameter int ADDR_WIDTH  = 7,
    parameter int COEFF_WIDTH = 16
);
    logic                   sample_valid;
    logic                   sample_ready;
    logic                   host_wr_valid;
    logic                   host_wr_ready;
    logic [ADDR_WIDTH-1:0]  host_wr_addr;
    logic [COEFF_WIDTH-1:0] host_wr_data;
    logic                   host_wr_err;
    logic                   mem_wr_en;
    logic [ADDR_WIDTH-1:0]  mem_wr_addr;
    logic [COEFF_WIDTH-1:0] mem_wr_data;
    logic                   mem_rd_en;
    logic [ADDR_WIDTH-1:0]  mem_rd_addr;
    logic                   tap_valid;
    logic [ADDR_WIDTH-1:0]  tap_index;
    logic                   tap_first;
    logic                   tap_last;
    logic                   busy;

    modport master (
        input  sample_valid, host_wr_valid, host_wr_addr, host_wr_data,
        output sample_ready, host_wr_ready, host_wr_err,
        output mem_wr_en, mem_wr_addr, mem_wr_data,
        output mem_rd_en, mem_rd_addr,
        output tap_valid, tap_index, tap_first, tap_last, busy
    );

    modport slave (
        output sample_valid, host_wr_valid, host_wr_addr, host_wr_data,
        input  sample_ready, host_wr_ready, host_wr_err,
        input  mem_wr_en, mem_wr_addr, mem_wr_data,
        input  mem_rd_en, mem_rd_addr,
        input  tap_valid, tap_index, tap_first, tap_last, busy
    );
endinterface
`default_nettype wire

// File: rtl/coeff_sweep_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : coeff_sweep_scheduler
//  Purpose  : Issues one coefficient read sweep (addresses 0..TAPS-1) per
//             accepted sample, emits tap-aligned qualifiers one cycle behind
//             the reads, and commits buffered host coefficient writes only
//             between sweeps.
//  Options  : COEFF_SWEEP_STATS_EN adds sweep_count / write_count outputs.
//  Revision : 1.0  initial release
// ============================================================================
module coeff_sweep_scheduler #(
    parameter int TAPS        = 128,
    parameter int COEFF_WIDTH = 16,
    parameter int ADDR_WIDTH  = 7
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    coeff_sweep_scheduler_if.master bus
`ifdef COEFF_SWEEP_STATS_EN
    ,
    output logic [15:0]             sweep_count,
    output logic [15:0]             write_count
`endif
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SWEEP = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_WRITE = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(TAPS - 1);

    logic [1:0]             r_state;
    logic [ADDR_WIDTH-1:0]  r_cnt;
    logic                   r_pending;
    logic [ADDR_WIDTH-1:0]  r_wr_addr;
    logic [COEFF_WIDTH-1:0] r_wr_data;
    logic                   r_err;
    logic                   r_run;
    logic                   r_tap_valid;
    logic [ADDR_WIDTH-1:0]  r_tap_index;
    logic                   r_tap_first;
    logic                   r_tap_last;

    logic w_idle;
    logic w_rd_en;
    logic w_wr_en;
    logic w_sample_ready;
    logic w_host_ready;
    logic w_sample_acc;
    logic w_host_acc;
    logic w_addr_oob;

    // r_run keeps both readies low while reset is held, so every output
    // reads 0 during reset; it rises on the first clock after release.
    assign w_idle         = (r_state == c_IDLE);
    assign w_rd_en        = (r_state == c_SWEEP);
    assign w_wr_en        = (r_state == c_WRITE);
    assign w_sample_ready = r_run && w_idle && !r_pending;
    assign w_host_ready   = r_run && !r_pending;
    assign w_sample_acc   = bus.sample_valid && w_sample_ready;
    assign w_host_acc     = bus.host_wr_valid && w_host_ready;
    assign w_addr_oob     = (32'(bus.host_wr_addr) >= 32'(TAPS));

    assign bus.sample_ready  = w_sample_ready;
    assign bus.host_wr_ready = w_host_ready;
    assign bus.host_wr_err   = r_err;
    assign bus.mem_wr_en     = w_wr_en;
    assign bus.mem_wr_addr   = w_wr_en ? r_wr_addr : '0;
    assign bus.mem_wr_data   = w_wr_en ? r_wr_data : '0;
    assign bus.mem_rd_en     = w_rd_en;
    assign bus.mem_rd_addr   = w_rd_en ? r_cnt : '0;
    assign bus.tap_valid     = r_tap_valid;
    assign bus.tap_index     = r_tap_index;
    assign bus.tap_first     = r_tap_first;
    assign bus.tap_last      = r_tap_last;
    assign bus.busy          = !w_idle || r_pending;

    // Sequencer: pending writes take priority over new samples in IDLE;
    // the read counter stops at the last address and the state moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (r_pending) begin
                        r_state <= c_WRITE;
                    end else if (w_sample_acc) begin
                        r_state <= c_SWEEP;
                        r_cnt   <= '0;
                    end
                end
                c_SWEEP: begin
                    if (r_cnt == c_LAST_ADDR) begin
                        r_state <= c_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_DRAIN: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                end
                c_WRITE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Host write holding register: an in-range write is held until the
    // WRITE state commits it; an out-of-range write only raises the error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_host_acc && w_addr_oob;
            if (w_wr_en) begin
                r_pending <= 1'b0;
            end else if (w_host_acc && !w_addr_oob) begin
                r_pending <= 1'b1;
                r_wr_addr <= bus.host_wr_addr;
                r_wr_data <= bus.host_wr_data;
            end
        end
    end

    // Run flag that releases the readies one clock after reset deasserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Tap qualifiers trail the read strobe by one cycle to line up with the
    // memory's registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tap_valid <= 1'b0;
            r_tap_index <= '0;
            r_tap_first <= 1'b0;
            r_tap_last  <= 1'b0;
        end else begin
            r_tap_valid <= w_rd_en;
            r_tap_index <= w_rd_en ? r_cnt : '0;
            r_tap_first <= w_rd_en && (r_cnt == '0);
            r_tap_last  <= w_rd_en && (r_cnt == c_LAST_ADDR);
        end
    end

`ifdef COEFF_SWEEP_STATS_EN
    // Activity counters: completed sweeps and committed writes, free-running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_count <= '0;
            write_count <= '0;
        end else begin
            if (r_tap_last) begin
                sweep_count <= sweep_count + 16'd1;
            end
            if (w_wr_en) begin
                write_count <= write_count + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
